// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for the 8-bit synchronous FIFO.
// Pops words from the FIFO read port and absorbs the one-cycle FIFO read
// latency in a 2-entry in-order skid buffer. The words are presented
// downstream as a valid/ready stream. Optional burst shaping inserts
// GAP_CYCLES idle cycles after every BURST_LEN accepted pops.
// Optional statistics: define FIFO_READER_STATS_EN to add rd_count0
// (handshake counter) and collide0 (dropped-request pulse).
module fifo_reader #(
   parameter int DATA_W     = 8,
   parameter int BURST_LEN  = 4,
   parameter int GAP_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst0,
   input  logic              empty0,
   input  logic              full0,
   input  logic              wr_active0,
   input  logic [DATA_W-1:0] fifo_data0,
   output logic              read_enable0,
   output logic [DATA_W-1:0] m_data0,
   output logic              m_valid0,
   input  logic              m_ready0
`ifdef FIFO_READER_STATS_EN
   ,
   output logic [15:0]       rd_count0,
   output logic              collide0
`endif
);

   typedef enum logic [0:0] {
      ST_RUN = 1'b0,
      ST_GAP = 1'b1
   } state_t;

   // Counter compare values; GAP_LAST is only consulted while in ST_GAP,
   // which is unreachable when GAP_CYCLES is 0.
   localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);
   localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
   localparam bit         GAP_EN     = (GAP_CYCLES > 0);

   state_t            state_q, state_d;
   logic [7:0]        bcnt_q, bcnt_d;
   logic [7:0]        gcnt_q, gcnt_d;
   logic              inflight_q;
   logic [1:0]        occ_q, occ_d;
   logic [DATA_W-1:0] buf0_q, buf0_d;
   logic [DATA_W-1:0] buf1_q, buf1_d;

   logic              hs_s;
   logic              collide_s;
   logic              accept_s;
   logic              room_s;
   logic [2:0]        fill_s;
   logic [2:0]        limit_s;

   // Head of the skid buffer drives the stream directly from registers.
   assign m_data0  = buf0_q;
   assign m_valid0 = (occ_q != 2'd0);
   assign hs_s     = m_valid0 & m_ready0;

   // Read request: only issue when the buffer can take the word once it
   // lands, counting the word already in flight and the one leaving now.
   always_comb begin
      fill_s       = {1'b0, occ_q} + {2'b00, inflight_q};
      limit_s      = 3'd2 + {2'b00, hs_s};
      room_s       = (fill_s < limit_s);
      collide_s    = wr_active0 & ~full0;
      read_enable0 = rst0 & (state_q == ST_RUN) & ~empty0 & room_s;
      accept_s     = read_enable0 & ~collide_s;
   end

   // Skid buffer next state: capture of the in-flight word and downstream
   // handshake, keeping words in arrival order.
   always_comb begin
      occ_d  = occ_q;
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      case ({inflight_q, hs_s})
         2'b10: begin
            occ_d = occ_q + 2'd1;
            if (occ_q == 2'd0) begin
               buf0_d = fifo_data0;
            end else begin
               buf1_d = fifo_data0;
            end
         end
         2'b01: begin
            occ_d  = occ_q - 2'd1;
            buf0_d = buf1_q;
         end
         2'b11: begin
            // Head leaves while a new word lands: occupancy is unchanged.
            if (occ_q == 2'd1) begin
               buf0_d = fifo_data0;
            end else begin
               buf0_d = buf1_q;
               buf1_d = fifo_data0;
            end
         end
         default: begin
            occ_d = occ_q;
         end
      endcase
   end

   // Burst shaping: count accepted pops in RUN, idle for GAP_CYCLES in GAP.
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      gcnt_d  = gcnt_q;
      case (state_q)
         ST_RUN: begin
            if (accept_s) begin
               if (bcnt_q == BURST_LAST) begin
                  bcnt_d = 8'd0;
                  gcnt_d = 8'd0;
                  if (GAP_EN) begin
                     state_d = ST_GAP;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else begin
                  bcnt_d = bcnt_q + 8'd1;
               end
            end else begin
               // Dropped or absent request: burst position holds.
               bcnt_d = bcnt_q;
            end
         end
         ST_GAP: begin
            if (gcnt_q == GAP_LAST) begin
               gcnt_d  = 8'd0;
               state_d = ST_RUN;
            end else begin
               gcnt_d = gcnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State registers; reset discards any in-flight word and clears the buffer.
   always_ff @(posedge clk) begin
      if (!rst0) begin
         state_q    <= ST_RUN;
         bcnt_q     <= 8'd0;
         gcnt_q     <= 8'd0;
         inflight_q <= 1'b0;
         occ_q      <= 2'd0;
         buf0_q     <= '0;
         buf1_q     <= '0;
      end else begin
         state_q    <= state_d;
         bcnt_q     <= bcnt_d;
         gcnt_q     <= gcnt_d;
         inflight_q <= accept_s;
         occ_q      <= occ_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
      end
   end

`ifdef FIFO_READER_STATS_EN
   logic [15:0] rd_count_q;
   logic        collide_q;

   // Statistics: wrapping handshake count and one-cycle dropped-request pulse.
   always_ff @(posedge clk) begin
      if (!rst0) begin
         rd_count_q <= 16'd0;
         collide_q  <= 1'b0;
      end else begin
         if (hs_s) begin
            rd_count_q <= rd_count_q + 16'd1;
         end else begin
            rd_count_q <= rd_count_q;
         end
         collide_q <= read_enable0 & collide_s;
      end
   end

   assign rd_count0 = rd_count_q;
   assign collide0  = collide_q;
`else
   // Statistics outputs are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: two instances (BURST_LEN=4/GAP=0 and
// BURST_LEN=2/GAP=3), each fed by a small FIFO model. Words are pushed to a
// per-instance scoreboard when written into the FIFO model and compared on
// each stream handshake.
`timescale 1ns/1ps
module tb_fifo_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- instance A ----------------
   logic       rst_a = 1'b0, full_a = 1'b0, wr_act_a = 1'b0, ready_a = 1'b0;
   logic [7:0] wdata_a = 8'h00, fdata_a = 8'h00, mdata_a;
   logic       empty_a, re_a, mvalid_a, pop_a;
   logic [7:0] mem_a [0:63];
   logic [5:0] rp_a = 6'd0, wp_a = 6'd0;
   logic [7:0] sb_a [$];
   logic       stall_a = 1'b0;
   logic [7:0] held_a = 8'h00;
`ifdef FIFO_READER_STATS_EN
   logic [15:0] rdcnt_a;
   logic        coll_a;
`endif

   fifo_reader #(.DATA_W(8), .BURST_LEN(4), .GAP_CYCLES(0)) u_dut_a (
      .clk(clk), .rst0(rst_a), .empty0(empty_a), .full0(full_a),
      .wr_active0(wr_act_a), .fifo_data0(fdata_a), .read_enable0(re_a),
      .m_data0(mdata_a), .m_valid0(mvalid_a), .m_ready0(ready_a)
`ifdef FIFO_READER_STATS_EN
      , .rd_count0(rdcnt_a), .collide0(coll_a)
`endif
   );

   assign empty_a = (rp_a == wp_a);
   assign pop_a   = re_a & ~empty_a & ~(wr_act_a & ~full_a);

   always @(posedge clk) begin
      if (pop_a) begin
         fdata_a <= mem_a[rp_a];
         rp_a    <= rp_a + 6'd1;
      end
      if (wr_act_a & ~full_a) begin
         mem_a[wp_a] <= wdata_a;
         wp_a        <= wp_a + 6'd1;
      end
   end

   always @(negedge clk) begin
      if (mvalid_a === 1'b1 && ready_a === 1'b1) begin
         if (sb_a.size() == 0) check_eq("a_extra_word", sb_a.size(), 1);
         else check_eq("a_stream", {24'd0, mdata_a}, {24'd0, sb_a.pop_front()});
      end
      if (stall_a) begin
         check_eq("a_hold_valid", mvalid_a, 1);
         check_eq("a_hold_data", mdata_a, held_a);
      end
      stall_a <= mvalid_a & ~ready_a & rst_a;
      held_a  <= mdata_a;
   end

   // ---------------- instance B ----------------
   logic       rst_b = 1'b0, full_b = 1'b0, wr_act_b = 1'b0, ready_b = 1'b0;
   logic [7:0] wdata_b = 8'h00, fdata_b = 8'h00, mdata_b;
   logic       empty_b, re_b, mvalid_b, pop_b;
   logic [7:0] mem_b [0:63];
   logic [5:0] rp_b = 6'd0, wp_b = 6'd0;
   logic [7:0] sb_b [$];
`ifdef FIFO_READER_STATS_EN
   logic [15:0] rdcnt_b;
   logic        coll_b;
`endif

   fifo_reader #(.DATA_W(8), .BURST_LEN(2), .GAP_CYCLES(3)) u_dut_b (
      .clk(clk), .rst0(rst_b), .empty0(empty_b), .full0(full_b),
      .wr_active0(wr_act_b), .fifo_data0(fdata_b), .read_enable0(re_b),
      .m_data0(mdata_b), .m_valid0(mvalid_b), .m_ready0(ready_b)
`ifdef FIFO_READER_STATS_EN
      , .rd_count0(rdcnt_b), .collide0(coll_b)
`endif
   );

   assign empty_b = (rp_b == wp_b);
   assign pop_b   = re_b & ~empty_b & ~(wr_act_b & ~full_b);

   always @(posedge clk) begin
      if (pop_b) begin
         fdata_b <= mem_b[rp_b];
         rp_b    <= rp_b + 6'd1;
      end
      if (wr_act_b & ~full_b) begin
         mem_b[wp_b] <= wdata_b;
         wp_b        <= wp_b + 6'd1;
      end
   end

   always @(negedge clk) begin
      if (mvalid_b === 1'b1 && ready_b === 1'b1) begin
         if (sb_b.size() == 0) check_eq("b_extra_word", sb_b.size(), 1);
         else check_eq("b_stream", {24'd0, mdata_b}, {24'd0, sb_b.pop_front()});
      end
   end

   // ---------------- helpers ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic write_a(input logic [7:0] d);
      wr_act_a = 1'b1;
      wdata_a  = d;
      sb_a.push_back(d);
      next_cycle();
      wr_act_a = 1'b0;
   endtask

   task automatic write_b(input logic [7:0] d);
      wr_act_b = 1'b1;
      wdata_b  = d;
      sb_b.push_back(d);
      next_cycle();
      wr_act_b = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [6:0]  exp_v7;
      logic [6:0]  exp_re7;
      logic [6:0]  exp_pop7;
      logic [6:0]  exp_col7;
      logic [5:0]  exp_v6;
      logic [12:0] exp_re13;
      logic [7:0]  drop_w;
      int          npops;

      repeat (3) next_cycle();

      // Reset state of both instances
      @(negedge clk);
      check_eq("a_rst_re", re_a, 0);
      check_eq("a_rst_valid", mvalid_a, 0);
      check_eq("a_rst_data", mdata_a, 0);
      check_eq("b_rst_re", re_b, 0);
      check_eq("b_rst_valid", mvalid_b, 0);
`ifdef FIFO_READER_STATS_EN
      check_eq("a_rst_rdcount", rdcnt_a, 0);
      check_eq("a_rst_collide", coll_a, 0);
`endif

      // Latency / throughput: preload under reset, then release with ready=1
      next_cycle();
      write_a(8'h11); write_a(8'h22); write_a(8'h33); write_a(8'h44);
      @(negedge clk);
      check_eq("a_re_low_in_reset", re_a, 0);
      next_cycle();
      ready_a  = 1'b1;
      rst_a    = 1'b1;
      exp_v7   = 7'b0111100;
      exp_re7  = 7'b0001111;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         check_eq("a_lat_valid", mvalid_a, exp_v7[c]);
         check_eq("a_lat_re", re_a, exp_re7[c]);
         next_cycle();
      end

      // Backpressure: ready held low, only two pops may be taken
      ready_a = 1'b0;
      write_a(8'h11); write_a(8'h22); write_a(8'h33); write_a(8'h44); write_a(8'h55);
      npops = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (pop_a) npops++;
         next_cycle();
      end
      check_eq("a_bp_pops", npops, 2);
      @(negedge clk);
      check_eq("a_bp_re", re_a, 0);
      check_eq("a_bp_valid", mvalid_a, 1);
      check_eq("a_bp_data", mdata_a, 8'h11);
      next_cycle();
      ready_a = 1'b1;
      exp_v6  = 6'b011111;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check_eq("a_bp_drain_valid", mvalid_a, exp_v6[c]);
         next_cycle();
      end

      // Empty FIFO for 10 cycles
`ifdef FIFO_READER_STATS_EN
      check_eq("a_rdcount_before_empty", rdcnt_a, 9);
`endif
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_eq("a_empty_re", re_a, 0);
         check_eq("a_empty_valid", mvalid_a, 0);
         next_cycle();
      end
`ifdef FIFO_READER_STATS_EN
      check_eq("a_rdcount_after_empty", rdcnt_a, 9);
`endif

      // Reset one cycle after the first accepted pop
      rst_a = 1'b0;
      write_a(8'hA1); write_a(8'hA2); write_a(8'hA3);
      rst_a = 1'b1;
      @(negedge clk);
      check_eq("a_mid_first_req", pop_a, 1);
      next_cycle();
      rst_a  = 1'b0;
      drop_w = sb_a.pop_front();   // 0xA1 is in flight and lost at reset
      @(negedge clk);
      check_eq("a_mid_re_in_reset", re_a, 0);
      next_cycle();
      rst_a = 1'b1;
      @(negedge clk);
      check_eq("a_mid_valid", mvalid_a, 0);
      check_eq("a_mid_data", mdata_a, 0);
      check_eq("a_mid_dropped_word", drop_w, 8'hA1);
      repeat (8) next_cycle();
      check_eq("a_sb_drained", sb_a.size(), 0);
`ifdef FIFO_READER_STATS_EN
      check_eq("a_rdcount_after_reset", rdcnt_a, 2);
`endif

      // Burst gap on B: pairs of pops separated by 3 idle cycles
      ready_b = 1'b1;
      write_b(8'hB1); write_b(8'hB2); write_b(8'hB3);
      write_b(8'hB4); write_b(8'hB5); write_b(8'hB6);
      rst_b    = 1'b1;
      exp_re13 = 13'b0110001100011;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         check_eq("b_gap_re", re_b, exp_re13[c]);
         next_cycle();
      end
      repeat (4) next_cycle();
      check_eq("b_gap_sb_drained", sb_b.size(), 0);

      // Writer collision on the second request of a burst
      rst_b = 1'b0;
      write_b(8'hC1); write_b(8'hC2); write_b(8'hC3);
      rst_b    = 1'b1;
      exp_re7  = 7'b1000111;
      exp_pop7 = 7'b1000101;
      exp_col7 = 7'b0000100;
      for (int c = 0; c < 7; c++) begin
         if (c == 1) begin
            wr_act_b = 1'b1;
            wdata_b  = 8'hC4;
            sb_b.push_back(8'hC4);
         end else begin
            wr_act_b = 1'b0;
         end
         @(negedge clk);
         check_eq("b_col_re", re_b, exp_re7[c]);
         check_eq("b_col_pop", pop_b, exp_pop7[c]);
`ifdef FIFO_READER_STATS_EN
         check_eq("b_col_pulse", coll_b, exp_col7[c]);
`endif
         next_cycle();
      end
      wr_act_b = 1'b0;
      repeat (10) next_cycle();
      check_eq("b_col_sb_drained", sb_b.size(), 0);
`ifdef FIFO_READER_STATS_EN
      check_eq("b_rdcount", rdcnt_b, 4);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
